// File: rtl/fetch_stream.sv
// fetch_stream: assembles a step witness delivered as LSB-first WORD_W-bit beats
// over valid/ready, splits it into instruction, register file and hint fields,
// and presents each step on a valid/ready output with a running step index.
// Framing violations (early or missing in_last) drop the step, pulse framing_err,
// and bump a saturating error counter.
// Optional feature macro FETCH_STREAM_SKID_EN: the single output register becomes
// a 2-entry FIFO so the final beat of a step rarely stalls.
// Assumes STEP_W > WORD_W (at least two beats per step).
module fetch_stream #(
  parameter int WORD_W    = 32,
  parameter int INSTR_W   = 96,
  parameter int REG_W     = 320,
  parameter int HINT_W    = 72,
  parameter int NUM_HINTS = 2,
  parameter int IDX_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTR_W-1:0]          raw_instr,
  output logic [REG_W-1:0]            raw_regs,
  output logic [NUM_HINTS*HINT_W-1:0] raw_hints,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        framing_err,
  output logic [15:0]                 err_cnt
);

  localparam int STEP_W = INSTR_W + REG_W + NUM_HINTS * HINT_W;
  localparam int BEATS  = (STEP_W + WORD_W - 1) / WORD_W;
  // Bits held in the buffer (all beats but the final one) and the useful width
  // of the final beat; anything above LAST_W in the final beat is pad.
  localparam int PART_W = (BEATS - 1) * WORD_W;
  localparam int LAST_W = STEP_W - PART_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    ASSEMBLE = 1'b0,
    DRAIN    = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [PART_W-1:0]   part_p0;
  logic [STEP_W-1:0]   step_nxt;
  logic [STEP_W-1:0]   out_step;
  logic                out_full;
  logic                assembling;
  logic                at_last;
  logic                accept;
  logic                complete;
  logic                early_last;
  logic                missing_last;
  logic                pop;

  assign assembling   = (state == ASSEMBLE);
  assign at_last      = (beat_cnt == LAST_CNT);
  assign accept       = in_valid && in_ready;
  assign complete     = accept && assembling && at_last && in_last;
  assign early_last   = accept && assembling && !at_last && in_last;
  assign missing_last = accept && assembling && at_last && !in_last;
  assign pop          = out_valid && out_ready;

  // The final beat goes straight into the output stage together with the
  // buffered beats, so the step is presented one cycle after its last beat.
  assign step_nxt = {in_data[LAST_W-1:0], part_p0};

  // Only the completing beat can stall, and only when the output has no room
  // that will be freed this cycle; out_ready is the one combinational input.
  assign in_ready = rst_n && !(assembling && at_last && out_full && !out_ready);

  // Framing FSM: counts beats, detects early/missing last, counts errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ASSEMBLE;
      beat_cnt    <= '0;
      framing_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      framing_err <= 1'b0;
      if (accept) begin
        case (state)
          ASSEMBLE: begin
            if (in_last || at_last) begin
              beat_cnt <= '0;
              if (early_last || missing_last) begin
                framing_err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                  err_cnt <= err_cnt + 16'd1;
                end
              end
              if (missing_last) begin
                state <= DRAIN;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
          DRAIN: begin
            // The error was already counted on entry; just wait for the end marker.
            if (in_last) begin
              state <= ASSEMBLE;
            end
          end
          default: state <= ASSEMBLE;
        endcase
      end
    end
  end

  // Stage p0: beats 0..BEATS-2 land at their LSB-first slot of the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_p0 <= '0;
    end else if (accept && assembling) begin
      for (int k = 0; k < BEATS - 1; k++) begin
        if (beat_cnt == CNT_W'(k)) begin
          part_p0[k*WORD_W +: WORD_W] <= in_data;
        end
      end
    end
  end

`ifdef FETCH_STREAM_SKID_EN

  logic [STEP_W-1:0] fifo_step_p1 [2];
  logic [IDX_W-1:0]  fifo_idx_p1  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fill;
  logic [IDX_W-1:0]  push_idx;

  // Stage p1: 2-entry output FIFO; each entry is tagged with its index at push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 2; e++) begin
        fifo_step_p1[e] <= '0;
        fifo_idx_p1[e]  <= '0;
      end
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fill     <= 2'd0;
      push_idx <= '0;
    end else begin
      if (complete) begin
        fifo_step_p1[wr_ptr] <= step_nxt;
        fifo_idx_p1[wr_ptr]  <= push_idx;
        wr_ptr               <= !wr_ptr;
        push_idx             <= push_idx + IDX_W'(1);
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      fill <= fill + {1'b0, complete} - {1'b0, pop};
    end
  end

  assign out_valid = (fill != 2'd0);
  assign out_full  = (fill == 2'd2);
  assign out_step  = fifo_step_p1[rd_ptr];
  assign out_idx   = fifo_idx_p1[rd_ptr];

`else

  logic [STEP_W-1:0] step_p1;
  logic              vld_p1;
  logic [IDX_W-1:0]  idx_p1;

  // Stage p1: single output register; holds while stalled, counts consumed steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_p1 <= '0;
      vld_p1  <= 1'b0;
      idx_p1  <= '0;
    end else begin
      if (pop) begin
        idx_p1 <= idx_p1 + IDX_W'(1);
      end
      if (complete) begin
        step_p1 <= step_nxt;
        vld_p1  <= 1'b1;
      end else if (pop) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_full  = vld_p1;
  assign out_step  = step_p1;
  assign out_idx   = idx_p1;

`endif

  assign raw_instr = out_step[INSTR_W-1:0];
  assign raw_regs  = out_step[INSTR_W +: REG_W];
  assign raw_hints = out_step[INSTR_W+REG_W +: NUM_HINTS*HINT_W];

endmodule

// File: tb/tb_fetch_stream.sv
// tb_fetch_stream: directed scenarios plus a randomized stream checked against a
// step-level reference model (beat lists, framing rules, FIFO of expected steps).
module tb_fetch_stream;

  localparam int WORD_W  = 32;
  localparam int INSTR_W = 96;
  localparam int REG_W   = 320;
  localparam int HINTS_W = 144;
  localparam int STEP_W  = INSTR_W + REG_W + HINTS_W;
  localparam int BEATS   = 18;
`ifdef FETCH_STREAM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] raw_instr;
  logic [REG_W-1:0]   raw_regs;
  logic [HINTS_W-1:0] raw_hints;
  logic [31:0]        out_idx;
  logic               framing_err;
  logic [15:0]        err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [STEP_W-1:0] exp_q [$];
  logic [31:0]       cur_q [$];
  bit                m_drain;
  int                m_err;
  int                m_pops;
  bit                m_pulse;

  fetch_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .raw_instr(raw_instr), .raw_regs(raw_regs), .raw_hints(raw_hints),
    .out_idx(out_idx), .framing_err(framing_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [STEP_W-1:0] pack_step(input logic [31:0] b [BEATS]);
    logic [STEP_W-1:0] s;
    s = '0;
    for (int k = 0; k < BEATS; k++)
      for (int j = 0; j < 32; j++)
        if (k * 32 + j < STEP_W) s[k*32+j] = b[k][j];
    return s;
  endfunction

  function automatic logic [STEP_W-1:0] observed();
    return {raw_hints, raw_regs, raw_instr};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete(); cur_q.delete();
    m_drain = 0; m_err = 0; m_pops = 0; m_pulse = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // Step-level framing rules: a step is exactly BEATS beats ending in last.
  task automatic model_beat(input logic [31:0] d, input logic l);
    logic [31:0] b [BEATS];
    if (m_drain) begin
      if (l) m_drain = 0;
      return;
    end
    cur_q.push_back(d);
    if (l) begin
      if (cur_q.size() == BEATS) begin
        for (int k = 0; k < BEATS; k++) b[k] = cur_q[k];
        exp_q.push_back(pack_step(b));
      end else begin
        m_err++; m_pulse = 1;
      end
      cur_q.delete();
    end else if (cur_q.size() == BEATS) begin
      m_err++; m_pulse = 1; m_drain = 1;
      cur_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    in_valid = 1;
    rst_n = 0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0 || framing_err !== 1'b0) begin n_err++; $display("FAIL reset_valid_err: out_valid=%b framing_err=%b want 0 0", out_valid, framing_err); end
    n_vec++; if (err_cnt !== 16'd0 || out_idx !== 32'd0) begin n_err++; $display("FAIL reset_counts: err_cnt=%0d out_idx=%0d want 0 0", err_cnt, out_idx); end
    n_vec++; if (observed() !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", observed()); end
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_nominal();
    logic [31:0] b [BEATS];
    do_reset();
    for (int k = 0; k < BEATS; k++) begin
      b[k] = 32'h1000_0000 + k;
      drive(1'b1, b[k], k == BEATS - 1, 1'b1);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL nominal_beat%0d: in_ready=%b out_valid=%b want 1 0", k, in_ready, out_valid); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nominal_valid: got %b want 1", out_valid); end
    n_vec++; if (raw_instr !== 96'h10000002_10000001_10000000) begin n_err++; $display("FAIL nominal_instr: got %h want 100000021000000110000000", raw_instr); end
    n_vec++; if (out_idx !== 32'd0) begin n_err++; $display("FAIL nominal_idx: got %0d want 0", out_idx); end
    n_vec++; if (observed() !== pack_step(b)) begin n_err++; $display("FAIL nominal_step: got %h want %h", observed(), pack_step(b)); end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b0 || out_idx !== 32'd1) begin n_err++; $display("FAIL nominal_consumed: out_valid=%b out_idx=%0d want 0 1", out_valid, out_idx); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a [BEATS];
    logic [31:0] b [BEATS];
    logic [STEP_W-1:0] sa, sb;
    do_reset();
    for (int k = 0; k < BEATS; k++) begin a[k] = $urandom; b[k] = $urandom; end
    sa = pack_step(a); sb = pack_step(b);
    for (int k = 0; k < BEATS; k++) begin
      drive(1'b1, a[k], k == BEATS - 1, 1'b0);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_a_beat%0d: in_ready=%b want 1", k, in_ready); end
    end
    for (int k = 0; k < BEATS - 1; k++) begin
      drive(1'b1, b[k], 1'b0, 1'b0);
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_idx !== 32'd0) begin n_err++; $display("FAIL bp_b_beat%0d: in_ready=%b out_valid=%b out_idx=%0d want 1 1 0", k, in_ready, out_valid, out_idx); end
      n_vec++; if (observed() !== sa) begin n_err++; $display("FAIL bp_hold%0d: got %h want %h", k, observed(), sa); end
    end
`ifdef FETCH_STREAM_SKID_EN
    drive(1'b1, b[BEATS-1], 1'b1, 1'b0);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_skid_nostall: in_ready=%b want 1", in_ready); end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b1 || observed() !== sa || out_idx !== 32'd0) begin n_err++; $display("FAIL bp_skid_first: valid=%b idx=%0d data=%h want 1 0 %h", out_valid, out_idx, observed(), sa); end
`else
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b[BEATS-1], 1'b1, 1'b0);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d: in_ready=%b want 0", i, in_ready); end
      n_vec++; if (observed() !== sa) begin n_err++; $display("FAIL bp_stall_hold%0d: got %h want %h", i, observed(), sa); end
    end
    drive(1'b1, b[BEATS-1], 1'b1, 1'b1);
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || observed() !== sa || out_idx !== 32'd0) begin n_err++; $display("FAIL bp_release: ready=%b valid=%b idx=%0d data=%h want 1 1 0 %h", in_ready, out_valid, out_idx, observed(), sa); end
`endif
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 32'd1) begin n_err++; $display("FAIL bp_second: out_valid=%b out_idx=%0d want 1 1", out_valid, out_idx); end
    n_vec++; if (observed() !== sb) begin n_err++; $display("FAIL bp_second_data: got %h want %h", observed(), sb); end
  endtask

  task automatic test_early_last();
    logic [31:0] b [BEATS];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, $urandom, k == 5, 1'b1);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL early_beat%0d: in_ready=%b want 1", k, in_ready); end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (framing_err !== 1'b1 || err_cnt !== 16'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL early_pulse: framing_err=%b err_cnt=%0d out_valid=%b want 1 1 0", framing_err, err_cnt, out_valid); end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (framing_err !== 1'b0 || err_cnt !== 16'd1) begin n_err++; $display("FAIL early_after: framing_err=%b err_cnt=%0d want 0 1", framing_err, err_cnt); end
    for (int k = 0; k < BEATS; k++) begin
      b[k] = $urandom;
      drive(1'b1, b[k], k == BEATS - 1, 1'b0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 32'd0 || observed() !== pack_step(b)) begin n_err++; $display("FAIL early_recover: valid=%b idx=%0d data=%h want 1 0 %h", out_valid, out_idx, observed(), pack_step(b)); end
  endtask

  task automatic test_missing_last();
    logic [31:0] b [BEATS];
    int pulses;
    bit seen_valid;
    do_reset();
    pulses = 0; seen_valid = 0;
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, $urandom, k == 23, 1'b1);
      n_vec++; if (in_ready !== 1'b1 || framing_err !== (k == 18)) begin n_err++; $display("FAIL missing_beat%0d: in_ready=%b framing_err=%b want 1 %b", k, in_ready, framing_err, k == 18); end
      pulses += int'(framing_err);
      seen_valid |= out_valid;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      pulses += int'(framing_err);
      seen_valid |= out_valid;
    end
    n_vec++; if (pulses != 1 || err_cnt !== 16'd1 || seen_valid) begin n_err++; $display("FAIL missing_summary: pulses=%0d err_cnt=%0d seen_valid=%b want 1 1 0", pulses, err_cnt, seen_valid); end
    for (int k = 0; k < BEATS; k++) begin
      b[k] = $urandom;
      drive(1'b1, b[k], k == BEATS - 1, 1'b0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 32'd0 || observed() !== pack_step(b)) begin n_err++; $display("FAIL missing_recover: valid=%b idx=%0d data=%h want 1 0 %h", out_valid, out_idx, observed(), pack_step(b)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b [BEATS];
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b1);
    drive(1'b1, $urandom, 1'b1, 1'b1);
    for (int k = 0; k < BEATS; k++) drive(1'b1, $urandom, k == BEATS - 1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < BEATS; k++) drive(1'b1, $urandom, k == BEATS - 1, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b1, $urandom, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 32'd1 || err_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_before: valid=%b idx=%0d err_cnt=%0d want 1 1 1", out_valid, out_idx, err_cnt); end
    in_valid = 0;
    rst_n = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_idx !== 32'd0 || err_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_async: valid=%b idx=%0d err_cnt=%0d want 0 0 0", out_valid, out_idx, err_cnt); end
    n_vec++; if (observed() !== '0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_data: data=%h in_ready=%b want 0 0", observed(), in_ready); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int k = 0; k < BEATS; k++) begin
      b[k] = $urandom;
      drive(1'b1, b[k], k == BEATS - 1, 1'b0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_idx !== 32'd0 || observed() !== pack_step(b)) begin n_err++; $display("FAIL midrst_fresh: valid=%b idx=%0d data=%h want 1 0 %h", out_valid, out_idx, observed(), pack_step(b)); end
  endtask

  task automatic test_field_split();
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   regs;
    logic [71:0]        hint_hi, hint_lo;
    logic [BEATS*32-1:0] full;
    do_reset();
    instr = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) regs[i*32 +: 32] = $urandom;
    hint_hi = 72'hAAAAAAAAAAAAAAAAAA;
    hint_lo = 72'h555555555555555555;
    full = {16'hFFFF, hint_hi, hint_lo, regs, instr};
    for (int k = 0; k < BEATS; k++) drive(1'b1, full[k*32 +: 32], k == BEATS - 1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (raw_hints[143:72] !== hint_hi) begin n_err++; $display("FAIL split_hint_hi: got %h want %h", raw_hints[143:72], hint_hi); end
    n_vec++; if (raw_hints[71:0] !== hint_lo) begin n_err++; $display("FAIL split_hint_lo: got %h want %h", raw_hints[71:0], hint_lo); end
    n_vec++; if (raw_regs !== regs || raw_instr !== instr) begin n_err++; $display("FAIL split_regs_instr: regs=%h instr=%h want %h %h", raw_regs, raw_instr, regs, instr); end
  endtask

  task automatic test_random();
    logic v, l, r, pend, exp_rdy;
    logic [31:0] d;
    int gpos;
    do_reset();
    pend = 0; gpos = 0; v = 0; l = 0; d = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend) begin
        v = ($urandom % 4) != 0;
        d = $urandom;
        l = (gpos == BEATS - 1);
        if ($urandom % 25 == 0) l = !l;
        if (gpos >= BEATS + 4) l = 1;
      end
      r = ($urandom % 3) != 0;
      drive(v, d, l, r);
      exp_rdy = !(cur_q.size() == BEATS - 1 && !m_drain && exp_q.size() == CAP && !r);
      n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
      n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, exp_q.size() != 0); end
      if (out_valid && exp_q.size() != 0) begin
        n_vec++; if (observed() !== exp_q[0] || out_idx !== 32'(m_pops)) begin n_err++; $display("FAIL rand_step c%0d: idx=%0d data=%h want %0d %h", c, out_idx, observed(), m_pops, exp_q[0]); end
      end
      n_vec++; if (framing_err !== m_pulse || err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL rand_err c%0d: framing_err=%b err_cnt=%0d want %b %0d", c, framing_err, err_cnt, m_pulse, m_err); end
      m_pulse = 0;
      if (out_valid && r && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (v && in_ready) begin
        model_beat(d, l);
        gpos = l ? 0 : gpos + 1;
        pend = 0;
      end else begin
        pend = v;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_field_split();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
